execute_memory_register: RTL

- Pipeline register on the far side of the execute stage: captures ALU result, store data and memory/writeback control, and presents them to the memory-access stage.
- Unlike a free-running stage register, it uses a valid/ready handshake with a 2-entry skid buffer. The memory stage can therefore stall without dropping data or combinationally back-propagating ready.
- Also squashes condition-failed instructions and supports pipeline flush on branch.

---
 rtl/execute_memory_register.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/execute_memory_register.sv
// Execute-to-memory pipeline register.
// A main (output) entry plus one skid entry, joined by a valid/ready handshake,
// so the memory stage can stall without losing data and without a
// combinational ready path back into execute. Instructions whose condition
// failed are kept in order but have their side-effect controls cleared, and a
// saturating counter records how many of them were accepted. flush empties
// both entries.
module execute_memory_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validIN,
  output logic                      readyOUT,
  input  logic [DATA_WIDTH-1:0]     aluResultIN,
  input  logic [DATA_WIDTH-1:0]     storeDataIN,
  input  logic [REG_ADDR_WIDTH-1:0] rdIN,
  input  logic                      loadStoreIN,
  input  logic                      memAccessIN,
  input  logic                      byteOrWordIN,
  input  logic                      regWriteIN,
  input  logic                      linkBitIN,
  input  logic                      condPassIN,
  input  logic                      flush,
  output logic                      validOUT,
  input  logic                      readyIN,
  output logic [DATA_WIDTH-1:0]     aluResultOUT,
  output logic [DATA_WIDTH-1:0]     storeDataOUT,
  output logic [REG_ADDR_WIDTH-1:0] rdOUT,
  output logic                      loadStoreOUT,
  output logic                      memAccessOUT,
  output logic                      byteOrWordOUT,
  output logic                      regWriteOUT,
  output logic                      linkBitOUT,
  output logic [15:0]               squashCount
);

  // Payload packing, MSB to LSB:
  // aluResult | storeData | rd | loadStore | memAccess | byteOrWord | regWrite | linkBit
  localparam int PW = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 5;

  logic [PW-1:0] in_payload_s;
  logic [PW-1:0] main_r;
  logic [PW-1:0] skid_r;
  logic [PW-1:0] main_nxt_s;
  logic [PW-1:0] skid_nxt_s;
  logic          main_valid_r;
  logic          skid_valid_r;
  logic          main_valid_nxt_s;
  logic          skid_valid_nxt_s;
  logic          ready_r;
  logic [15:0]   squash_cnt_r;
  logic [15:0]   squash_cnt_nxt_s;
  logic          accept_s;
  logic          advance_s;
  logic          squash_s;

  assign accept_s  = validIN & ready_r;
  // Main may take new contents when it is empty or its entry is being consumed.
  assign advance_s = ~main_valid_r | readyIN;
  assign squash_s  = ~condPassIN;

  // Build the incoming entry; a failed condition strips all architectural side effects.
  always_comb begin
    in_payload_s = {aluResultIN, storeDataIN, rdIN, loadStoreIN,
                    memAccessIN & ~squash_s, byteOrWordIN,
                    regWriteIN & ~squash_s, linkBitIN & ~squash_s};
  end

  // Next-state of the two-entry buffer: flush, then drain skid, then pass-through, then stall.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    if (flush) begin
      // Payload is left stale; only the valid bits matter.
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (advance_s) begin
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_nxt_s       = skid_r;
        skid_valid_nxt_s = accept_s;
        if (accept_s) begin
          skid_nxt_s = in_payload_s;
        end else begin
          skid_nxt_s = skid_r;
        end
      end else begin
        main_valid_nxt_s = accept_s;
        skid_valid_nxt_s = 1'b0;
        if (accept_s) begin
          main_nxt_s = in_payload_s;
        end else begin
          main_nxt_s = main_r;
        end
      end
    end else begin
      // Main is full and stalled: its payload must stay put.
      if (accept_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_nxt_s       = in_payload_s;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
        skid_nxt_s       = skid_r;
      end
    end
  end

  // Saturating count of accepted condition-failed instructions; a flushed accept is not counted.
  always_comb begin
    squash_cnt_nxt_s = squash_cnt_r;
    if (!flush && accept_s && squash_s && (squash_cnt_r != 16'hFFFF)) begin
      squash_cnt_nxt_s = squash_cnt_r + 16'd1;
    end else begin
      squash_cnt_nxt_s = squash_cnt_r;
    end
  end

  // State registers; ready is registered from the next skid occupancy so it never depends on readyIN combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_r       <= {PW{1'b0}};
      skid_r       <= {PW{1'b0}};
      ready_r      <= 1'b1;
      squash_cnt_r <= 16'd0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      ready_r      <= ~skid_valid_nxt_s;
      squash_cnt_r <= squash_cnt_nxt_s;
    end
  end

  assign readyOUT      = ready_r;
  assign validOUT      = main_valid_r;
  assign squashCount   = squash_cnt_r;
  assign aluResultOUT  = main_r[PW-1 -: DATA_WIDTH];
  assign storeDataOUT  = main_r[PW-DATA_WIDTH-1 -: DATA_WIDTH];
  assign rdOUT         = main_r[REG_ADDR_WIDTH+4 -: REG_ADDR_WIDTH];
  assign loadStoreOUT  = main_r[4];
  assign memAccessOUT  = main_r[3];
  assign byteOrWordOUT = main_r[2];
  assign regWriteOUT   = main_r[1];
  assign linkBitOUT    = main_r[0];

endmodule
